// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared types and default constants for the instruction fetch stage.
//   fetch_state_e : fetch controller states (IDLE after reset, FETCH, DISCARD)
//   DefAddrW      : default PC / instruction-memory address width
//   DefInstrW     : default instruction word width
//   DefDepth      : default fetch FIFO depth
//   DefResetPc    : PC value loaded after reset
package ifetch_pkg;

  localparam int unsigned DefAddrW   = 8;
  localparam int unsigned DefInstrW  = 16;
  localparam int unsigned DefDepth   = 2;
  localparam logic [7:0]  DefResetPc = 8'h00;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DISCARD
  } fetch_state_e;

endpackage

// File: rtl/instr_fifo.sv
// instr_fifo: DEPTH-entry synchronous FIFO holding packed {instr, pc} fetch entries.
//   clk_i / rst_ni : clock, asynchronous active-low reset
//   push_i         : write data_i at the tail (ignored when full)
//   pop_i          : drop the head entry (ignored when empty)
//   flush_i        : empty the FIFO at the next edge; wins over push_i and pop_i
//   data_i         : entry to write
//   data_o         : head entry (valid when !empty_o)
//   full_o/empty_o : occupancy flags, derived from registered count only
module instr_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 24
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (PtrW + 1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign data_o  = mem_q[rd_ptr_q];

  assign do_push = push_i & ~full_o & ~flush_i;
  assign do_pop  = pop_i & ~empty_o & ~flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so pointers wrap naturally.
      if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      count_d = count_q + (PtrW + 1)'(do_push) - (PtrW + 1)'(do_pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible once count says so.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction fetch stage between the PC register and decode.
//   clk, rst_n            : clock shared with the PC register, async active-low reset
//   pc_in / pc_next       : PC register output / next-value input (hold, +1 or redirect)
//   imem_req/addr/ack/rdata : instruction-memory handshake; ack is a one-cycle pulse
//                           with rdata valid in the same cycle
//   redirect_valid/pc     : one-cycle branch/jump redirect; flushes buffered fetches
//   instr_valid/ready/data/pc : FIFO head towards decode
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter int unsigned        ADDR_W   = DefAddrW,
  parameter int unsigned        INSTR_W  = DefInstrW,
  parameter int unsigned        DEPTH    = DefDepth,
  parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(DefResetPc)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ADDR_W-1:0]  pc_in,
  output logic [ADDR_W-1:0]  pc_next,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr_data,
  output logic [ADDR_W-1:0]  instr_pc
);

  localparam int unsigned EntryW = INSTR_W + ADDR_W;

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  abandon_q, abandon_d;
  logic               fifo_full, fifo_empty;
  logic               ack_fire, redirect_act;
  logic               push, pop, flush;
  logic [EntryW-1:0]  head;

  assign ack_fire     = imem_req & imem_ack;
  assign redirect_act = redirect_valid & (state_q != IDLE);

  // Ack data is kept only in FETCH and only when no redirect squashes it.
  assign push  = (state_q == FETCH) & ack_fire & ~redirect_act;
  assign pop   = instr_valid & instr_ready;
  assign flush = redirect_act;

  instr_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EntryW)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .data_i  ({imem_rdata, imem_addr}),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign instr_valid = ~fifo_empty;
  assign instr_data  = head[EntryW-1:ADDR_W];
  assign instr_pc    = head[ADDR_W-1:0];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      abandon_q <= RESET_PC;
    end else begin
      state_q   <= state_d;
      abandon_q <= abandon_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d   = state_q;
    abandon_d = abandon_q;
    unique case (state_q)
      IDLE: state_d = FETCH;
      FETCH, DISCARD: begin
        if (redirect_valid) begin
          // An outstanding request cannot be withdrawn; wait out its ack.
          state_d = (imem_req && !imem_ack) ? DISCARD : FETCH;
          if (state_q == FETCH) abandon_d = imem_addr;
        end else if (state_q == DISCARD && ack_fire) begin
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: request side depends on registered state and FIFO count only.
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = RESET_PC;
    unique case (state_q)
      IDLE: begin
        imem_req  = 1'b0;
        imem_addr = RESET_PC;
      end
      FETCH: begin
        imem_req  = ~fifo_full;
        imem_addr = pc_in;
      end
      DISCARD: begin
        imem_req  = 1'b1;
        imem_addr = abandon_q;
      end
      default: begin
        imem_req  = 1'b0;
        imem_addr = RESET_PC;
      end
    endcase
  end

  // PC loop: redirect beats advance, which beats hold.
  always_comb begin
    pc_next = pc_in;
    if (state_q == IDLE) begin
      pc_next = RESET_PC;
    end else if (redirect_valid) begin
      pc_next = redirect_pc;
    end else if (push) begin
      pc_next = pc_in + ADDR_W'(1);
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  pc_in;
  logic [7:0]  pc_next;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr_data;
  logic [7:0]  instr_pc;

  int n_checks = 0;
  int n_fail   = 0;
  int mem_lat  = 0;
  int mem_cnt;

  always #5 clk = ~clk;

  ifetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc_in          (pc_in),
    .pc_next        (pc_next),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc)
  );

  // PC register closing the loop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_in <= 8'h00;
    else        pc_in <= pc_next;
  end

  // Memory model: ack after mem_lat wait cycles (0 = same cycle), data = addr*3.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     mem_cnt <= 0;
    else if (imem_req && !imem_ack) mem_cnt <= mem_cnt + 1;
    else                            mem_cnt <= 0;
  end
  assign imem_ack   = imem_req && (mem_cnt >= mem_lat);
  assign imem_rdata = {8'h00, imem_addr} * 16'd3;

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk); #1;
    n_checks++; if (imem_req !== 1'b0) begin n_fail++;
      $display("FAIL reset_req: got %0b want 0", imem_req); end
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++;
      $display("FAIL reset_valid: got %0b want 0", instr_valid); end
    n_checks++; if (imem_addr !== 8'h00) begin n_fail++;
      $display("FAIL reset_addr: got %h want 00", imem_addr); end
    n_checks++; if (pc_next !== 8'h00) begin n_fail++;
      $display("FAIL reset_pc_next: got %h want 00", pc_next); end
    rst_n = 1'b1;
    #1;
    n_checks++; if (imem_req !== 1'b0) begin n_fail++;
      $display("FAIL idle_req: got %0b want 0", imem_req); end
    @(negedge clk); #1;
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin n_fail++;
      $display("FAIL first_req: req %0b addr %h want 1 00", imem_req, imem_addr); end
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++;
      $display("FAIL first_valid: got %0b want 0", instr_valid); end
  endtask

  task automatic test_stream();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); #1;
      n_checks++;
      if (instr_valid !== 1'b1 || instr_pc !== 8'(k) || instr_data !== 16'(k * 3)
          || imem_addr !== 8'(k + 1)) begin
        n_fail++;
        $display("FAIL stream_%0d: valid %0b pc %h data %h addr %h want 1 %h %h %h", k,
                 instr_valid, instr_pc, instr_data, imem_addr, 8'(k), 16'(k * 3), 8'(k + 1));
      end
    end
  endtask

  task automatic test_backpressure();
    instr_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      n_checks++;
      if (imem_req !== 1'b0 || pc_next !== 8'h09 || instr_pc !== 8'h07
          || instr_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL stall_%0d: req %0b pc_next %h head %h valid %0b want 0 09 07 1", i,
                 imem_req, pc_next, instr_pc, instr_valid);
      end
    end
    instr_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk); #1;
      n_checks++;
      if (instr_pc !== 8'(8 + j) || imem_addr !== 8'(9 + j) || imem_req !== 1'b1) begin
        n_fail++;
        $display("FAIL drain_%0d: head %h addr %h req %0b want %h %h 1", j, instr_pc,
                 imem_addr, imem_req, 8'(8 + j), 8'(9 + j));
      end
    end
  endtask

  task automatic test_wrap();
    logic [7:0]  exp_pc;
    logic [7:0]  exp_nxt;
    logic [15:0] exp_data;
    redirect_valid = 1'b1;
    redirect_pc    = 8'hFC;
    #1;
    n_checks++; if (pc_next !== 8'hFC) begin n_fail++;
      $display("FAIL wrap_redirect_pc_next: got %h want fc", pc_next); end
    @(negedge clk); #1;
    redirect_valid = 1'b0;
    #1;
    n_checks++; if (instr_valid !== 1'b0 || imem_addr !== 8'hFC) begin n_fail++;
      $display("FAIL wrap_after_redirect: valid %0b addr %h want 0 fc", instr_valid,
               imem_addr); end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); #1;
      exp_pc   = 8'hFC + 8'(k);
      exp_nxt  = exp_pc + 8'h01;
      exp_data = {8'h00, exp_pc} * 16'd3;
      n_checks++;
      if (instr_valid !== 1'b1 || instr_pc !== exp_pc || instr_data !== exp_data
          || imem_addr !== exp_nxt) begin
        n_fail++;
        $display("FAIL wrap_%0d: valid %0b pc %h data %h addr %h want 1 %h %h %h", k,
                 instr_valid, instr_pc, instr_data, imem_addr, exp_pc, exp_data, exp_nxt);
      end
    end
  endtask

  task automatic test_redirect_pending();
    bit found;
    redirect_valid = 1'b1;
    redirect_pc    = 8'h05;
    #1;
    n_checks++; if (pc_next !== 8'h05) begin n_fail++;
      $display("FAIL pend_redirect0: pc_next %h want 05", pc_next); end
    @(negedge clk); #1;
    redirect_valid = 1'b0;
    mem_lat        = 3;
    #1;
    n_checks++; if (imem_req !== 1'b1 || imem_ack !== 1'b0 || imem_addr !== 8'h05
                    || instr_valid !== 1'b0) begin n_fail++;
      $display("FAIL pend_req05: req %0b ack %0b addr %h valid %0b want 1 0 05 0", imem_req,
               imem_ack, imem_addr, instr_valid); end
    @(negedge clk); #1;
    redirect_valid = 1'b1;
    redirect_pc    = 8'h40;
    #1;
    n_checks++; if (pc_next !== 8'h40 || imem_req !== 1'b1) begin n_fail++;
      $display("FAIL pend_redirect40: pc_next %h req %0b want 40 1", pc_next, imem_req); end
    @(negedge clk); #1;
    redirect_valid = 1'b0;
    #1;
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 8'h05 || instr_valid !== 1'b0
                    || pc_next !== 8'h40) begin n_fail++;
      $display("FAIL pend_discard: req %0b addr %h valid %0b pc_next %h want 1 05 0 40",
               imem_req, imem_addr, instr_valid, pc_next); end
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      @(negedge clk); #1;
      if (instr_valid) found = 1'b1;
    end
    n_checks++;
    if (!found || instr_pc !== 8'h40 || instr_data !== 16'h00C0) begin n_fail++;
      $display("FAIL pend_first40: found %0b pc %h data %h want 1 40 00c0", found, instr_pc,
               instr_data); end
  endtask

  task automatic test_redirect_ack();
    bit found;
    for (int i = 0; i < 8 && !imem_ack; i++) begin
      @(negedge clk); #1;
    end
    n_checks++; if (imem_ack !== 1'b1 || imem_addr !== 8'h41) begin n_fail++;
      $display("FAIL ack41_wait: ack %0b addr %h want 1 41", imem_ack, imem_addr); end
    redirect_valid = 1'b1;
    redirect_pc    = 8'h60;
    #1;
    n_checks++; if (pc_next !== 8'h60) begin n_fail++;
      $display("FAIL ack_redirect60: pc_next %h want 60", pc_next); end
    @(negedge clk); #1;
    redirect_valid = 1'b0;
    mem_lat        = 5;
    #1;
    n_checks++; if (imem_addr !== 8'h60 || instr_valid !== 1'b0 || imem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL ack_req60: addr %h valid %0b req %0b want 60 0 1", imem_addr,
               instr_valid, imem_req); end
    @(negedge clk); #1;
    redirect_valid = 1'b1;
    redirect_pc    = 8'h70;
    #1;
    n_checks++; if (pc_next !== 8'h70) begin n_fail++;
      $display("FAIL ack_redirect70: pc_next %h want 70", pc_next); end
    @(negedge clk); #1;
    redirect_valid = 1'b0;
    #1;
    n_checks++; if (imem_addr !== 8'h60 || imem_req !== 1'b1) begin n_fail++;
      $display("FAIL ack_discard60: addr %h req %0b want 60 1", imem_addr, imem_req); end
    @(negedge clk); #1;
    redirect_valid = 1'b1;
    redirect_pc    = 8'h80;
    #1;
    n_checks++; if (pc_next !== 8'h80 || imem_addr !== 8'h60) begin n_fail++;
      $display("FAIL ack_redirect80: pc_next %h addr %h want 80 60", pc_next, imem_addr); end
    @(negedge clk); #1;
    redirect_valid = 1'b0;
    #1;
    n_checks++; if (imem_addr !== 8'h60 || imem_req !== 1'b1 || pc_next !== 8'h80) begin
      n_fail++;
      $display("FAIL ack_still_discard: addr %h req %0b pc_next %h want 60 1 80", imem_addr,
               imem_req, pc_next); end
    found = 1'b0;
    for (int i = 0; i < 15 && !found; i++) begin
      @(negedge clk); #1;
      if (instr_valid) found = 1'b1;
    end
    n_checks++;
    if (!found || instr_pc !== 8'h80 || instr_data !== 16'h0180) begin n_fail++;
      $display("FAIL ack_first80: found %0b pc %h data %h want 1 80 0180", found, instr_pc,
               instr_data); end
  endtask

  task automatic test_reset_mid();
    instr_ready = 1'b0;
    mem_lat     = 0;
    @(negedge clk); #1;
    n_checks++; if (instr_valid !== 1'b1 || imem_req !== 1'b0 || instr_pc !== 8'h80) begin
      n_fail++;
      $display("FAIL mid_full: valid %0b req %0b head %h want 1 0 80", instr_valid, imem_req,
               instr_pc); end
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b0 || imem_addr !== 8'h00
                    || pc_next !== 8'h00) begin n_fail++;
      $display("FAIL mid_reset: valid %0b req %0b addr %h pc_next %h want 0 0 00 00",
               instr_valid, imem_req, imem_addr, pc_next); end
    @(negedge clk); #1;
    rst_n       = 1'b1;
    instr_ready = 1'b1;
    #1;
    n_checks++; if (imem_req !== 1'b0) begin n_fail++;
      $display("FAIL mid_idle_req: got %0b want 0", imem_req); end
    @(negedge clk); #1;
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin n_fail++;
      $display("FAIL mid_restart: req %0b addr %h want 1 00", imem_req, imem_addr); end
    @(negedge clk); #1;
    n_checks++; if (instr_valid !== 1'b1 || instr_pc !== 8'h00 || instr_data !== 16'h0000)
    begin n_fail++;
      $display("FAIL mid_first: valid %0b pc %h data %h want 1 00 0000", instr_valid,
               instr_pc, instr_data); end
  endtask

  initial begin
    rst_n          = 1'b0;
    instr_ready    = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 8'h00;
    test_reset();
    test_stream();
    test_backpressure();
    test_wrap();
    test_redirect_pending();
    test_redirect_ack();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
